ikascc_busif: RTL and testbench

IKASCC_BUSIF -- requirements
Module: ikascc_busif

---
 rtl/ikascc_busif_if.sv | 26 ++
 rtl/ikascc_busif.sv | 120 ++++++++++++
 tb/tb_ikascc_busif.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ikascc_busif_if.sv
// Cartridge bus strobes/address/data in, synchronized write request and captured
// values out. The slave modport is the bus interface block; the master modport is the bus driver.
interface ikascc_busif_if;
  logic       i_CS_n;
  logic       i_WR_n;
  logic       i_RD_n;
  logic [7:0] i_DB;
  logic [4:0] i_ABHI;
  logic [7:0] i_ABLO;
  logic       o_WRRQ;
  logic [7:0] o_DB;
  logic [4:0] o_ABHI;
  logic [7:0] o_ABLO;
  logic       o_RDACT;
  logic [7:0] o_WRCNT;

  modport slave (
    input  i_CS_n, i_WR_n, i_RD_n, i_DB, i_ABHI, i_ABLO,
    output o_WRRQ, o_DB, o_ABHI, o_ABLO, o_RDACT, o_WRCNT
  );

  modport master (
    output i_CS_n, i_WR_n, i_RD_n, i_DB, i_ABHI, i_ABLO,
    input  o_WRRQ, o_DB, o_ABHI, o_ABLO, o_RDACT, o_WRCNT
  );
endinterface

// File: rtl/ikascc_busif.sv
// Cartridge bus interface: synchronizes async strobes on phiM enables and issues one write request per write.
// Optional write-strobe glitch filter: define IKASCC_BUSIF_GLITCH_FILTER_EN.
module ikascc_busif #(
  parameter int unsigned FILTER_LEN = 2
) (
  input  logic           i_EMUCLK,
  input  logic           i_RST_n,
  input  logic           i_MCLK_PCEN_n,
  ikascc_busif_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_REQ     = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  // Out-of-range filter lengths leave this block empty; the legal range is 1..7.
  if (FILTER_LEN < 1 || FILTER_LEN > 7) begin : g_filter_len_out_of_range
  end

  logic [1:0] r_cs_s;
  logic [1:0] r_wr_s;
  logic [1:0] r_rd_s;
  logic [1:0] r_state;
  logic       r_wrrq;
  logic       r_rdact;
  logic [7:0] r_wrcnt;
  logic [7:0] r_db;
  logic [4:0] r_abhi;
  logic [7:0] r_ablo;
  logic       w_wr_act;
  logic       w_rd_act;

`ifdef IKASCC_BUSIF_GLITCH_FILTER_EN
  localparam logic [2:0] L_FILT_LEN = 3'(FILTER_LEN);
  logic [2:0] r_filt_cnt;
  logic [2:0] w_filt_nxt;

  assign w_filt_nxt = r_filt_cnt + 3'd1;
`endif

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_cs_s <= '1;
      r_wr_s <= '1;
      r_rd_s <= '1;
    end else if (!i_MCLK_PCEN_n) begin
      r_cs_s <= {r_cs_s[0], bus.i_CS_n};
      r_wr_s <= {r_wr_s[0], bus.i_WR_n};
      r_rd_s <= {r_rd_s[0], bus.i_RD_n};
    end
  end

  assign w_wr_act = ~r_cs_s[1] & ~r_wr_s[1];
  assign w_rd_act = ~r_cs_s[1] & ~r_rd_s[1];

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_state <= ST_IDLE;
      r_wrrq  <= 1'b0;
      r_rdact <= 1'b0;
      r_wrcnt <= '0;
      r_db    <= '0;
      r_abhi  <= '0;
      r_ablo  <= '0;
`ifdef IKASCC_BUSIF_GLITCH_FILTER_EN
      r_filt_cnt <= '0;
`endif
    end else if (!i_MCLK_PCEN_n) begin
      // Read activity is only reported while no write owns the bus.
      r_rdact <= w_rd_act & ~w_wr_act & (r_state == ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_wr_act) begin
            r_state <= ST_ARM;
            r_db    <= bus.i_DB;
            r_abhi  <= bus.i_ABHI;
            r_ablo  <= bus.i_ABLO;
          end
        end
        ST_ARM: begin
`ifdef IKASCC_BUSIF_GLITCH_FILTER_EN
          if (!w_wr_act) begin
            r_state    <= ST_IDLE;
            r_filt_cnt <= '0;
          end else if (w_filt_nxt >= L_FILT_LEN) begin
            r_state    <= ST_REQ;
            r_wrrq     <= 1'b1;
            r_filt_cnt <= '0;
          end else begin
            r_filt_cnt <= w_filt_nxt;
          end
`else
          r_state <= ST_REQ;
          r_wrrq  <= 1'b1;
`endif
        end
        ST_REQ: begin
          r_state <= ST_RELEASE;
          r_wrrq  <= 1'b0;
          r_wrcnt <= r_wrcnt + 8'd1;
        end
        ST_RELEASE: begin
          if (!w_wr_act) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_WRRQ  = r_wrrq;
  assign bus.o_RDACT = r_rdact;
  assign bus.o_WRCNT = r_wrcnt;
  assign bus.o_DB    = r_db;
  assign bus.o_ABHI  = r_abhi;
  assign bus.o_ABLO  = r_ablo;

endmodule

// File: tb/tb_ikascc_busif.sv
// Bench for ikascc_busif: directed scenarios plus randomized strobes against a transaction-level model.
module tb_ikascc_busif;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pcen_n = 1'b1;
  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  bit          last_en = 1'b0;

  ikascc_busif_if bus_if ();

  ikascc_busif #(.FILTER_LEN(2)) dut (
    .i_EMUCLK      (clk),
    .i_RST_n       (rst_n),
    .i_MCLK_PCEN_n (pcen_n),
    .bus           (bus_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: strobes sampled on an enabled edge become visible two enabled edges later;
  // a write is tracked by its age in enabled edges since capture.
  logic [2:0] m_hist[$];
  bit         m_busy;
  int         m_age;
  bit         m_wrrq;
  bit         m_rdact;
  logic [7:0] m_cnt;
  logic [7:0] m_db;
  logic [4:0] m_abhi;
  logic [7:0] m_ablo;

  task automatic model_reset();
    m_hist.delete();
    m_hist.push_back(3'b111);
    m_hist.push_back(3'b111);
    m_busy = 0; m_age = 0; m_wrrq = 0; m_rdact = 0;
    m_cnt = 8'h00; m_db = 8'h00; m_abhi = 5'h00; m_ablo = 8'h00;
  endtask

  task automatic model_edge();
    logic [2:0] old;
    bit wa, ra;
    old = m_hist.pop_front();
    wa = !old[2] && !old[1];
    ra = !old[2] && !old[0];
    m_rdact = ra && !wa && !m_busy;
    if (!m_busy) begin
      if (wa) begin
        m_busy = 1; m_age = 0;
        m_db = bus_if.i_DB; m_abhi = bus_if.i_ABHI; m_ablo = bus_if.i_ABLO;
      end
    end else begin
      m_age++;
      if (m_age == 1) m_wrrq = 1;
      else if (m_age == 2) begin m_wrrq = 0; m_cnt = m_cnt + 8'd1; end
      else if (!wa) m_busy = 0;
    end
    m_hist.push_back({bus_if.i_CS_n, bus_if.i_WR_n, bus_if.i_RD_n});
  endtask

  // One EMUCLK cycle; PCEN is low on every 4th clock. Returns at posedge+1.
  task automatic step();
    pcen_n = ((cyc % 4) != 3);
    cyc++;
    @(posedge clk);
    last_en = rst_n && !pcen_n;
    if (last_en) model_edge();
    #1;
  endtask

  task automatic step_en(input int n);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        if (last_en) break;
      end
    end
  endtask

  task automatic strobes(input logic cs, input logic wr, input logic rd);
    bus_if.i_CS_n = cs; bus_if.i_WR_n = wr; bus_if.i_RD_n = rd;
  endtask

  task automatic reset_dut();
    strobes(1, 1, 1);
    rst_n = 1'b0;
    model_reset();
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic do_write(input logic [7:0] db);
    bus_if.i_DB = db;
    strobes(0, 0, 1);
    step_en(5);
    strobes(1, 1, 1);
    step_en(4);
  endtask

  task automatic test_reset();
    strobes(1, 1, 1);
    bus_if.i_DB = 8'($urandom); bus_if.i_ABHI = 5'($urandom); bus_if.i_ABLO = 8'($urandom);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bus_if.o_WRRQ !== 1'b0) begin failures++; $display("FAIL reset_wrrq: got %b expected 0", bus_if.o_WRRQ); end
    checks++; if (bus_if.o_RDACT !== 1'b0) begin failures++; $display("FAIL reset_rdact: got %b expected 0", bus_if.o_RDACT); end
    checks++; if (bus_if.o_WRCNT !== 8'h00) begin failures++; $display("FAIL reset_wrcnt: got %h expected 00", bus_if.o_WRCNT); end
    checks++; if (bus_if.o_DB !== 8'h00) begin failures++; $display("FAIL reset_db: got %h expected 00", bus_if.o_DB); end
    checks++; if (bus_if.o_ABHI !== 5'h00) begin failures++; $display("FAIL reset_abhi: got %h expected 00", bus_if.o_ABHI); end
    checks++; if (bus_if.o_ABLO !== 8'h00) begin failures++; $display("FAIL reset_ablo: got %h expected 00", bus_if.o_ABLO); end
    step(); step();
    rst_n = 1'b1;
    step_en(3);
    checks++; if (bus_if.o_WRCNT !== 8'h00 || bus_if.o_WRRQ !== 1'b0) begin
      failures++; $display("FAIL reset_idle: got cnt=%h wrrq=%b expected cnt=00 wrrq=0", bus_if.o_WRCNT, bus_if.o_WRRQ);
    end
  endtask

  task automatic test_single_write();
    int e = 0, rise_e = -1, width = 0, pulses = 0;
    logic [7:0] ablo, db_at_rise = 8'h00;
    logic [4:0] abhi_at_rise = 5'h00;
    bit prev = 0;
    reset_dut();
    ablo = 8'($urandom);
    bus_if.i_DB = 8'h5A; bus_if.i_ABHI = 5'b10010; bus_if.i_ABLO = ablo;
    strobes(0, 0, 1);
    for (int c = 0; c < 200 && e < 20; c++) begin
      step();
      if (last_en) e++;
      if (bus_if.o_WRRQ && !prev) begin
        pulses++; rise_e = e; db_at_rise = bus_if.o_DB; abhi_at_rise = bus_if.o_ABHI;
      end
      if (bus_if.o_WRRQ) width++;
      prev = bus_if.o_WRRQ;
      if (last_en && e == 12) strobes(1, 1, 1);
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
    checks++; if (rise_e != 4) begin failures++; $display("FAIL single_latency: got edge %0d expected 4", rise_e); end
    checks++; if (width != 4) begin failures++; $display("FAIL single_width: got %0d clocks expected 4", width); end
    checks++; if (db_at_rise !== 8'h5A) begin failures++; $display("FAIL single_db: got %h expected 5a", db_at_rise); end
    checks++; if (abhi_at_rise !== 5'h12) begin failures++; $display("FAIL single_abhi: got %h expected 12", abhi_at_rise); end
    checks++; if (bus_if.o_ABLO !== ablo) begin failures++; $display("FAIL single_ablo: got %h expected %h", bus_if.o_ABLO, ablo); end
    checks++; if (bus_if.o_WRCNT !== 8'h01) begin failures++; $display("FAIL single_wrcnt: got %h expected 01", bus_if.o_WRCNT); end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    int exp_pulses;
    bit prev = 0;
`ifdef IKASCC_BUSIF_GLITCH_FILTER_EN
    exp_pulses = 0;
`else
    exp_pulses = 1;
`endif
    reset_dut();
    bus_if.i_DB = 8'($urandom);
    strobes(0, 0, 1);
    step_en(1);
    strobes(1, 1, 1);
    for (int c = 0; c < 48; c++) begin
      step();
      if (bus_if.o_WRRQ && !prev) pulses++;
      prev = bus_if.o_WRRQ;
    end
    checks++; if (pulses != exp_pulses) begin failures++; $display("FAIL glitch_pulses: got %0d expected %0d", pulses, exp_pulses); end
    checks++; if (bus_if.o_WRCNT !== 8'(exp_pulses)) begin failures++; $display("FAIL glitch_wrcnt: got %h expected %0d", bus_if.o_WRCNT, exp_pulses); end
  endtask

  task automatic test_rd_wr();
    int pulses = 0, rd_seen = 0;
    bit prev = 0;
    reset_dut();
    strobes(0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus_if.o_RDACT) rd_seen++;
      if (bus_if.o_WRRQ && !prev) pulses++;
      prev = bus_if.o_WRRQ;
    end
    checks++; if (rd_seen != 0) begin failures++; $display("FAIL rdwr_rdact_low: got %0d high clocks expected 0", rd_seen); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL rdwr_pulses: got %0d expected 1", pulses); end
    strobes(0, 1, 0);
    step_en(6);
    checks++; if (bus_if.o_RDACT !== 1'b1) begin failures++; $display("FAIL rdwr_rdact_high: got %b expected 1", bus_if.o_RDACT); end
    checks++; if (bus_if.o_WRCNT !== 8'h01) begin failures++; $display("FAIL rdwr_wrcnt: got %h expected 01", bus_if.o_WRCNT); end
    strobes(1, 1, 1);
    step_en(3);
  endtask

  task automatic test_wrap();
    logic [7:0] d = 8'h00;
    reset_dut();
    for (int i = 0; i < 255; i++) do_write(8'($urandom));
    checks++; if (bus_if.o_WRCNT !== 8'hFF) begin failures++; $display("FAIL wrap_preload: got %h expected ff", bus_if.o_WRCNT); end
    d = 8'($urandom);
    do_write(d);
    checks++; if (bus_if.o_WRCNT !== 8'h00) begin failures++; $display("FAIL wrap_rollover: got %h expected 00", bus_if.o_WRCNT); end
    checks++; if (bus_if.o_DB !== d) begin failures++; $display("FAIL wrap_last_db: got %h expected %h", bus_if.o_DB, d); end
  endtask

  task automatic test_reset_mid_req();
    bit found = 0, prev = 0;
    int pulses = 0;
    reset_dut();
    do_write(8'h11);
    strobes(0, 0, 1);
    for (int c = 0; c < 100 && !found; c++) begin
      step();
      if (bus_if.o_WRRQ) found = 1;
    end
    checks++; if (!found) begin failures++; $display("FAIL midreq_reach: got no request expected wrrq=1 within 100 clocks"); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bus_if.o_WRRQ !== 1'b0) begin failures++; $display("FAIL midreq_async_wrrq: got %b expected 0", bus_if.o_WRRQ); end
    checks++; if (bus_if.o_WRCNT !== 8'h00) begin failures++; $display("FAIL midreq_async_wrcnt: got %h expected 00", bus_if.o_WRCNT); end
    step(); step();
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      if (bus_if.o_WRRQ && !prev) pulses++;
      prev = bus_if.o_WRRQ;
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL midreq_new_pulses: got %0d expected 1", pulses); end
    checks++; if (bus_if.o_WRCNT !== 8'h01) begin failures++; $display("FAIL midreq_wrcnt: got %h expected 01", bus_if.o_WRCNT); end
    strobes(1, 1, 1);
    step_en(4);
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) bus_if.i_CS_n = ~bus_if.i_CS_n;
      if ($urandom_range(0, 5) == 0) bus_if.i_WR_n = ~bus_if.i_WR_n;
      if ($urandom_range(0, 5) == 0) bus_if.i_RD_n = ~bus_if.i_RD_n;
      bus_if.i_DB = 8'($urandom); bus_if.i_ABHI = 5'($urandom); bus_if.i_ABLO = 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
      checks++; if (bus_if.o_WRRQ !== m_wrrq) begin failures++; $display("FAIL rand_wrrq @%0d: got %b expected %b", c, bus_if.o_WRRQ, m_wrrq); end
      checks++; if (bus_if.o_RDACT !== m_rdact) begin failures++; $display("FAIL rand_rdact @%0d: got %b expected %b", c, bus_if.o_RDACT, m_rdact); end
      checks++; if (bus_if.o_WRCNT !== m_cnt) begin failures++; $display("FAIL rand_wrcnt @%0d: got %h expected %h", c, bus_if.o_WRCNT, m_cnt); end
      checks++; if (bus_if.o_DB !== m_db) begin failures++; $display("FAIL rand_db @%0d: got %h expected %h", c, bus_if.o_DB, m_db); end
      checks++; if (bus_if.o_ABHI !== m_abhi) begin failures++; $display("FAIL rand_abhi @%0d: got %h expected %h", c, bus_if.o_ABHI, m_abhi); end
      checks++; if (bus_if.o_ABLO !== m_ablo) begin failures++; $display("FAIL rand_ablo @%0d: got %h expected %h", c, bus_if.o_ABLO, m_ablo); end
    end
  endtask

  initial begin
    strobes(1, 1, 1);
    bus_if.i_DB = 8'h00; bus_if.i_ABHI = 5'h00; bus_if.i_ABLO = 8'h00;
    model_reset();
    test_reset();
    test_single_write();
    test_glitch();
    test_rd_wr();
    test_wrap();
    test_reset_mid_req();
`ifndef IKASCC_BUSIF_GLITCH_FILTER_EN
    test_random();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
